// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC and queue entry type for the fetch path
package fetch_pkg;
  localparam int          INST_W   = 32;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry shift FIFO of fetched words; slot 0 is the registered head
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t mem0_q, mem0_d;
  fetch_entry_t mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;

  // Slot 0 is left untouched when the queue empties so the head holds its last value.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            mem0_d  = push_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            mem0_d = push_data;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (push) begin
            mem1_d  = push_data;
            count_d = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            mem0_d = mem1_q;
            if (push) mem1_d = push_data;
            else      count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem0_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, range/alignment checks and prefetch queue feeding decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter int          IMEM_BYTES = 32,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] inst_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic        misalign_err
);
  localparam logic [1:0]  FULL_CNT  = 2'(QDEPTH);
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic [31:0]  pc_q, pc_d;
  logic         ferr_q, ferr_d;
  logic         merr_q, merr_d;
  logic         q_push, q_pop, q_flush;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_wdata;

  logic pop, in_range, can_push;

  assign pop      = inst_valid & inst_ready;
  assign in_range = (pc_q <= LAST_ADDR);
  assign can_push = (q_count < FULL_CNT) | pop;
  assign q_wdata  = '{pc: pc_q, inst: inst_in};

  always_comb begin
    pc_d    = pc_q;
    ferr_d  = ferr_q;
    merr_d  = merr_q;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    if (redirect_valid) begin
      // The in-flight word and any pending pop are dropped with the flush.
      q_flush = 1'b1;
      pc_d    = {redirect_pc[31:2], 2'b00};
      ferr_d  = 1'b0;
      merr_d  = merr_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      q_pop = pop;
      if (!in_range) begin
        ferr_d = 1'b1;
      end else if (can_push) begin
        q_push = 1'b1;
        pc_d   = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ferr_q <= 1'b0;
      merr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ferr_q <= ferr_d;
      merr_q <= merr_d;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (q_flush),
    .push_data (q_wdata),
    .count     (q_count),
    .head      (q_head)
  );

  assign pc_out       = pc_q;
  assign inst_valid   = (q_count != 2'd0);
  assign inst_out     = q_head.inst;
  assign inst_pc      = q_head.pc;
  assign fetch_err    = ferr_q;
  assign misalign_err = merr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus hand sequences for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic        misalign_err;

  logic [31:0] mem [0:7];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  assign inst_in = (pc_out < 32'd32) ? mem[pc_out[4:2]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .inst_in        (inst_in),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err),
    .misalign_err   (misalign_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic [31:0] e_pcout;
    logic        e_ferr;
    logic        e_merr;
    logic        chk_head;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic rv, input logic [31:0] rpc,
                     input logic v, input logic [31:0] o, input logic [31:0] p,
                     input logic [31:0] pco, input logic fe, input logic me, input logic ch);
    vec_t t;
    t = '{rst: r, rdy: rd, rv: rv, rpc: rpc, e_valid: v, e_out: o, e_pc: p,
          e_pcout: pco, e_ferr: fe, e_merr: me, chk_head: ch};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic rd, input logic rv, input logic [31:0] rpc);
    rst = r; inst_ready = rd; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] o,
                           input logic [31:0] p, input logic [31:0] pco,
                           input logic fe, input logic me, input logic ch);
    chk({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, "_pc_out"}, pc_out, pco);
    chk({tag, "_fetch_err"}, {31'd0, fetch_err}, {31'd0, fe});
    chk({tag, "_misalign_err"}, {31'd0, misalign_err}, {31'd0, me});
    if (ch) begin
      chk({tag, "_inst_out"}, inst_out, o);
      chk({tag, "_inst_pc"}, inst_pc, p);
    end
  endtask

  initial begin
    mem[0] = 32'h0000_2083; mem[1] = 32'h0040_2103;
    mem[2] = 32'h0020_E233; mem[3] = 32'h0020_81B3;
    mem[4] = 32'h4020_8233; mem[5] = 32'h0030_2023;
    mem[6] = 32'h0040_2223; mem[7] = 32'hFE42_00E3;
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Straight-line run, drain past the end of memory, then recover by redirect
    add(1, 1, 0, 0,       0, 0,       0,     0,     0, 0, 1);
    for (int k = 0; k < 8; k++)
      add(0, 1, 0, 0,     1, mem[k],  4*k,   4*k+4, 0, 0, 1);
    add(0, 1, 0, 0,       0, 0,       0,     32'h20, 1, 0, 0);
    add(0, 1, 0, 0,       0, 0,       0,     32'h20, 1, 0, 0);
    add(0, 1, 1, 32'h04,  0, 0,       0,     32'h04, 0, 0, 0);
    add(0, 1, 0, 0,       1, mem[1],  32'h4, 32'h08, 0, 0, 1);
    // Misaligned redirect sets the sticky flag; later aligned redirect keeps it
    add(0, 1, 1, 32'h06,  0, 0,       0,     32'h04, 0, 1, 0);
    add(0, 1, 0, 0,       1, mem[1],  32'h4, 32'h08, 0, 1, 1);
    add(0, 1, 1, 32'h10,  0, 0,       0,     32'h10, 0, 1, 0);
    add(0, 1, 0, 0,       1, mem[4],  32'h10, 32'h14, 0, 1, 1);
    // Reset clears it; then backpressure for five cycles
    add(1, 0, 0, 0,       0, 0,       0,     0,     0, 0, 1);
    add(0, 0, 0, 0,       1, mem[0],  0,     32'h04, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      add(0, 0, 0, 0,     1, mem[0],  0,     32'h08, 0, 0, 1);
    add(0, 1, 0, 0,       1, mem[1],  32'h4, 32'h0C, 0, 0, 1);
    add(0, 1, 0, 0,       1, mem[2],  32'h8, 32'h10, 0, 0, 1);
    add(0, 1, 0, 0,       1, mem[3],  32'hC, 32'h14, 0, 0, 1);
    // Queue full with 0x0C/0x10, redirect to 0 with pop ignored
    add(0, 0, 1, 32'h00,  0, 0,       0,     32'h00, 0, 0, 0);
    add(0, 1, 0, 0,       1, mem[0],  0,     32'h04, 0, 0, 1);
    add(0, 1, 0, 0,       1, mem[1],  32'h4, 32'h08, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check_all($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_out, vecs[i].e_pc,
                vecs[i].e_pcout, vecs[i].e_ferr, vecs[i].e_merr, vecs[i].chk_head);
    end

    // Fill the queue, then reset with a redirect in the same cycle
    drive(0, 0, 0, 0);
    check_all("full", 1, mem[1], 32'h4, 32'h0C, 0, 0, 1);
    drive(1, 1, 1, 32'h0000_0013);
    check_all("rst_redir", 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0);
    check_all("after_rst", 1, mem[0], 0, 32'h04, 0, 0, 1);
    drive(0, 1, 0, 0);
    check_all("after_rst2", 1, mem[1], 32'h4, 32'h08, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the byte address `pc_out` to `inst_mem`, whose read is combinational: `inst = mem[pc_out*8 +: 32]`.
- Captures each returned word together with its PC into a 2-entry prefetch queue.
- Presents the queue head to decode over a valid/ready handshake and supports redirect (branch/jump) with queue flush.

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset.
- `IMEM_BYTES`, `32`: instruction memory size in bytes. Valid fetch addresses are 0 to `IMEM_BYTES-4`.
- `QDEPTH`, `2`: prefetch queue depth. Only 2 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_out`  out  32  byte address to `inst_mem`.
- `inst_in`  in  32  instruction word from `inst_mem`, valid in the same cycle as `pc_out`.
- `inst_valid`  out  1  queue head is valid.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst_out`  out  32  instruction at queue head.
- `inst_pc`  out  32  PC of `inst_out`.
- `redirect_valid`  in  1  load a new PC (taken branch or jump).
- `redirect_pc`  in  32  redirect target.
- `fetch_err`  out  1  sticky: fetch address out of range.
- `misalign_err`  out  1  sticky: redirect target not word-aligned.

Behaviour:
- Reset (`rst`=1 at an edge): `pc_out`=`RESET_PC`, queue empty, `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `fetch_err`=0, `misalign_err`=0.
  - Reset overrides every other input, including mid-redirect and a full queue.
- Definitions:
  - `pop` = `inst_valid` & `inst_ready`.
  - `in_range` = (`pc_out` <= `IMEM_BYTES-4`).
  - `can_push` = (`count` < 2) | `pop`.
- Priority at each edge (highest first): `rst`, then `redirect_valid`, then normal fetch.
- Redirect:
  - Queue flushed (`count`=0); the in-flight word is discarded and `pop` is ignored.
  - `pc_out` <= `redirect_pc` & ~3.
  - `fetch_err` cleared.
  - `misalign_err` <= `misalign_err` | (`redirect_pc[1:0]` != 0). Cleared only by reset.
  - The first word from the target appears at the head one cycle after the redirect edge.
- Normal fetch:
  - If `can_push` & `in_range`: push {`pc_out`, `inst_in`} and `pc_out` <= `pc_out`+4 (modulo 2^32).
  - Otherwise `pc_out` holds.
  - If !`in_range` and no redirect: `fetch_err` <= 1 and no push occurs. `fetch_err` stays set until a redirect or reset.
- Queue:
  - FIFO order.
  - Push and pop in the same cycle leave `count` unchanged, including when full (`count`=2).
  - Full with no pop: no push, PC stalls.
  - Pop from an empty queue cannot occur, because `inst_valid`=0.
- Outputs:
  - `inst_valid` = (`count` != 0).
  - `inst_out` and `inst_pc` are the registered head entry. When empty they hold their last value (0 after reset).
  - Head output is stable while `inst_valid` & !`inst_ready`.
- Latency: with `inst_ready` held at 1, the first instruction is valid in the first cycle after reset deasserts. Steady-state throughput is one instruction per cycle.

Decomposition:
- Package `fetch_pkg`:
  - constants `INST_W`=32, `XLEN`=32, `RESET_PC`;
  - typedef `fetch_entry_t` = struct {`pc` [31:0], `inst` [31:0]}.
- Sub-module `fetch_queue`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, and head outputs.
- `fetch_unit` contains the PC register, range and alignment checks, error flags, and the `fetch_queue` instance.

Test Plan:
1. Reset then `inst_ready`=1 for 8 cycles, with `inst_mem` holding the standard 8-word program:
   - `inst_out` sequence 00002083, 00402103, 0020E233, 002081B3, 40208233, 00302023, 00402223, FE4200E3;
   - `inst_pc` sequence 0, 4, 8, …, 0x1C.
2. Backpressure, `inst_ready`=0 for 5 cycles after reset:
   - `count` reaches 2;
   - `pc_out` holds at 8;
   - head stays 00002083 / `pc`=0.
   Then `inst_ready`=1: heads 00002083, 00402103, 0020E233 on consecutive cycles, with no gap.
3. Redirect to 0x00 while `pc_out`=0x14 and the queue is full:
   - next cycle `inst_valid`=1 with `inst_pc`=0, `inst_out`=00002083;
   - stale entries 0x0C/0x10 are never presented.
4. Run past 0x1C with no redirect:
   - `pc_out` stops at 0x20;
   - `fetch_err`=1 after the last entry is pushed;
   - `inst_valid` drops once the queue drains.
   Then redirect to 0x04: `fetch_err`=0 and head becomes 00402103.
5. Redirect to 0x06: `pc_out`=0x04, `misalign_err`=1 and stays 1 through later aligned redirects until `rst`.
6. Assert `rst` mid-stream with the queue full and `redirect_valid`=1 in the same cycle:
   - all outputs return to their reset values;
   - `pc_out`=0;
   - the redirect is ignored.
